// File: rtl/conv_pkg.sv
// Shared types and defaults for the convolution layer sequencer.
package conv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ADVANCE,
        S_DONE
    } state_t;

    localparam int DEF_H            = 28;
    localparam int DEF_W            = 28;
    localparam int DEF_CHANNEL_SIZE = DEF_H * DEF_W;
    localparam int DEF_OC           = 7;
    localparam int DEF_IC           = 3;
    localparam int DEF_KTAPS        = 9;

    // Index register width; a single channel still gets one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_layer_sequencer_if.sv
// Control/address bundle between the layer sequencer (master) and its host/engine (slave).
interface conv_layer_sequencer_if
    import conv_pkg::*;
#(
    parameter int OC     = DEF_OC,
    parameter int IC     = DEF_IC,
    parameter int ADDR_W = 16
);
    logic                   start;
    logic                   abort;
    logic                   conv_done;
    logic                   conv_start;
    logic                   acc_clear;
    logic [idx_w(OC)-1:0]   oc_idx;
    logic [idx_w(IC)-1:0]   ic_idx;
    logic [ADDR_W-1:0]      in_base;
    logic [ADDR_W-1:0]      w_base;
    logic [ADDR_W-1:0]      out_base;
    logic                   cout_done;
    logic                   layer_done;
    logic                   busy;
    logic                   timeout_err;

    modport master (
        input  start, abort, conv_done,
        output conv_start, acc_clear, oc_idx, ic_idx, in_base, w_base, out_base,
               cout_done, layer_done, busy, timeout_err
    );

    modport slave (
        output start, abort, conv_done,
        input  conv_start, acc_clear, oc_idx, ic_idx, in_base, w_base, out_base,
               cout_done, layer_done, busy, timeout_err
    );
endinterface

// File: rtl/conv_seq_watchdog.sv
// Counts consecutive WAIT cycles; flags expiry on the LIMIT-th cycle without an answer.
module conv_seq_watchdog #(
    parameter int LIMIT = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic expired
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    assign expired = run && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/conv_layer_sequencer.sv
// Walks all (oc, ic) passes of a conv layer, ic inner, commanding the MAC engine.
// Optional watchdog on the engine handshake: define CONV_SEQ_TIMEOUT_EN.
module conv_layer_sequencer
    import conv_pkg::*;
#(
    parameter int CHANNEL_SIZE   = DEF_CHANNEL_SIZE,
    parameter int OC             = DEF_OC,
    parameter int IC             = DEF_IC,
    parameter int KTAPS          = DEF_KTAPS,
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    conv_layer_sequencer_if.master ifc
);
    localparam int OW = idx_w(OC);
    localparam int IW = idx_w(IC);

    state_t              state;
    logic [OW-1:0]       oc_q, oc_nxt;
    logic [IW-1:0]       ic_q, ic_nxt;
    logic                last_ic, last_oc;
    logic [ADDR_W-1:0]   in_base_q, w_base_q, out_base_q;
    logic                conv_start_q, acc_clear_q, cout_done_q, layer_done_q;

    function automatic logic [ADDR_W-1:0] chan_base(input int idx);
        return ADDR_W'(idx * CHANNEL_SIZE);
    endfunction

    function automatic logic [ADDR_W-1:0] kern_base(input int o, input int i);
        return ADDR_W'((o * IC + i) * KTAPS);
    endfunction

    always_comb begin
        last_ic = (ic_q == IW'(IC - 1));
        last_oc = (oc_q == OW'(OC - 1));
        ic_nxt  = last_ic ? '0 : ic_q + 1'b1;
        oc_nxt  = last_ic ? (last_oc ? '0 : oc_q + 1'b1) : oc_q;
    end

`ifdef CONV_SEQ_TIMEOUT_EN
    logic timeout_q;
    logic wd_expired;

    conv_seq_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .run     (state == S_WAIT),
        .expired (wd_expired)
    );
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            oc_q         <= '0;
            ic_q         <= '0;
            in_base_q    <= '0;
            w_base_q     <= '0;
            out_base_q   <= '0;
            conv_start_q <= 1'b0;
            acc_clear_q  <= 1'b0;
            cout_done_q  <= 1'b0;
            layer_done_q <= 1'b0;
`ifdef CONV_SEQ_TIMEOUT_EN
            timeout_q    <= 1'b0;
`endif
        end else begin
            conv_start_q <= 1'b0;
            acc_clear_q  <= 1'b0;
            cout_done_q  <= 1'b0;
            layer_done_q <= 1'b0;
            // Abort outranks everything, including a conv_done in the same cycle.
            if (state != S_IDLE && ifc.abort) begin
                state      <= S_IDLE;
                oc_q       <= '0;
                ic_q       <= '0;
                in_base_q  <= '0;
                w_base_q   <= '0;
                out_base_q <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (ifc.start) begin
                            state        <= S_ISSUE;
                            oc_q         <= '0;
                            ic_q         <= '0;
                            in_base_q    <= '0;
                            w_base_q     <= '0;
                            out_base_q   <= '0;
                            conv_start_q <= 1'b1;
                            acc_clear_q  <= 1'b1;
`ifdef CONV_SEQ_TIMEOUT_EN
                            timeout_q    <= 1'b0;
`endif
                        end
                    end
                    S_ISSUE: state <= S_WAIT;
                    S_WAIT: begin
                        if (ifc.conv_done) begin
                            state       <= S_ADVANCE;
                            cout_done_q <= last_ic;
                        end
`ifdef CONV_SEQ_TIMEOUT_EN
                        else if (wd_expired) begin
                            state      <= S_IDLE;
                            oc_q       <= '0;
                            ic_q       <= '0;
                            in_base_q  <= '0;
                            w_base_q   <= '0;
                            out_base_q <= '0;
                            timeout_q  <= 1'b1;
                        end
`endif
                    end
                    S_ADVANCE: begin
                        // Bases are computed from the next indices so they are valid in ISSUE.
                        oc_q       <= oc_nxt;
                        ic_q       <= ic_nxt;
                        in_base_q  <= chan_base(int'(ic_nxt));
                        w_base_q   <= kern_base(int'(oc_nxt), int'(ic_nxt));
                        out_base_q <= chan_base(int'(oc_nxt));
                        if (last_ic && last_oc) begin
                            state        <= S_DONE;
                            layer_done_q <= 1'b1;
                        end else begin
                            state        <= S_ISSUE;
                            conv_start_q <= 1'b1;
                            acc_clear_q  <= (ic_nxt == '0);
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign ifc.conv_start = conv_start_q;
    assign ifc.acc_clear  = acc_clear_q;
    assign ifc.cout_done  = cout_done_q;
    assign ifc.layer_done = layer_done_q;
    assign ifc.oc_idx     = oc_q;
    assign ifc.ic_idx     = ic_q;
    assign ifc.in_base    = in_base_q;
    assign ifc.w_base     = w_base_q;
    assign ifc.out_base   = out_base_q;
    assign ifc.busy       = (state != S_IDLE);

`ifdef CONV_SEQ_TIMEOUT_EN
    assign ifc.timeout_err = timeout_q;
`else
    // Watchdog compiled out; the term only keeps TIMEOUT_CYCLES referenced.
    assign ifc.timeout_err = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

endmodule
